// File: rtl/writeback_load_assemble.sv
// writeback_load_assemble: commits ALU results and assembles two 16-bit memory beats into 32-bit load writes
module writeback_load_assemble #(
    parameter int unsigned HALF_FIRST_LOW = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_valid_i,
    input  logic [31:0] data_calc_i,
    input  logic        mem_to_reg_i,
    input  logic        ld_half_i,
    input  logic        ld_signed_i,
    input  logic [3:0]  rf_wr_select_i,
    input  logic        rf_wr_en_i,
    input  logic [15:0] mem_rdata_i,
    output logic [31:0] rf_wr_data_o,
    output logic [3:0]  rf_wr_select_o,
    output logic        rf_wr_en_o,
    output logic        busy_o,
    output logic        overrun_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD_A, ST_LOAD_B} state_t;

    state_t      state_q, state_d;
    logic [3:0]  sel_q;
    logic        en_q, half_q, signed_q;
    logic [15:0] beat_a_q;
    logic        commit;
    logic [31:0] commit_data, half_ext, word_data;

    // State register; reset abandons any load in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: loads walk through one or two beat states, requests while busy are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = (wb_valid_i && mem_to_reg_i) ? ST_LOAD_A : ST_IDLE;
            ST_LOAD_A: state_d = half_q ? ST_IDLE : ST_LOAD_B;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: busy flag and the load data to commit this cycle
    always_comb begin
        busy_o      = state_q != ST_IDLE;
        half_ext    = {{16{signed_q & mem_rdata_i[15]}}, mem_rdata_i};
        word_data   = (HALF_FIRST_LOW != 0) ? {mem_rdata_i, beat_a_q} : {beat_a_q, mem_rdata_i};
        commit      = (state_q == ST_LOAD_A && half_q) || state_q == ST_LOAD_B;
        commit_data = (state_q == ST_LOAD_A) ? half_ext : word_data;
    end

    // Datapath: latch load controls, hold the first beat, drive the register-file write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_wr_data_o   <= '0;
            rf_wr_select_o <= '0;
            rf_wr_en_o     <= 1'b0;
            overrun_o      <= 1'b0;
            beat_a_q       <= '0;
            sel_q          <= '0;
            en_q           <= 1'b0;
            half_q         <= 1'b0;
            signed_q       <= 1'b0;
        end else begin
            rf_wr_en_o <= 1'b0;
            if (busy_o && wb_valid_i) overrun_o <= 1'b1;
            if (state_q == ST_LOAD_A && !half_q) beat_a_q <= mem_rdata_i;
            if (commit) begin
                rf_wr_data_o   <= commit_data;
                rf_wr_select_o <= sel_q;
                rf_wr_en_o     <= en_q;
            end
            if (!busy_o && wb_valid_i) begin
                if (mem_to_reg_i) begin
                    sel_q    <= rf_wr_select_i;
                    en_q     <= rf_wr_en_i;
                    half_q   <= ld_half_i;
                    signed_q <= ld_signed_i;
                end else begin
                    rf_wr_data_o   <= data_calc_i;
                    rf_wr_select_o <= rf_wr_select_i;
                    rf_wr_en_o     <= rf_wr_en_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_load_assemble.sv
// tb_writeback_load_assemble: directed checks of ALU writes, word/half loads, overrun, reset and back-to-back
module tb_writeback_load_assemble;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic [31:0] data_calc_i = '0;
    logic        mem_to_reg_i = 1'b0;
    logic        ld_half_i = 1'b0;
    logic        ld_signed_i = 1'b0;
    logic [3:0]  rf_wr_select_i = '0;
    logic        rf_wr_en_i = 1'b0;
    logic [15:0] mem_rdata_i = '0;

    logic [31:0] data_0, data_1;
    logic [3:0]  sel_0, sel_1;
    logic        en_0, en_1, busy_0, busy_1, ovr_0, ovr_1;

    int passed = 0;
    int total = 0;

    writeback_load_assemble #(.HALF_FIRST_LOW(1)) u_low (
        .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .data_calc_i(data_calc_i),
        .mem_to_reg_i(mem_to_reg_i), .ld_half_i(ld_half_i), .ld_signed_i(ld_signed_i),
        .rf_wr_select_i(rf_wr_select_i), .rf_wr_en_i(rf_wr_en_i), .mem_rdata_i(mem_rdata_i),
        .rf_wr_data_o(data_0), .rf_wr_select_o(sel_0), .rf_wr_en_o(en_0),
        .busy_o(busy_0), .overrun_o(ovr_0)
    );

    writeback_load_assemble #(.HALF_FIRST_LOW(0)) u_high (
        .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .data_calc_i(data_calc_i),
        .mem_to_reg_i(mem_to_reg_i), .ld_half_i(ld_half_i), .ld_signed_i(ld_signed_i),
        .rf_wr_select_i(rf_wr_select_i), .rf_wr_en_i(rf_wr_en_i), .mem_rdata_i(mem_rdata_i),
        .rf_wr_data_o(data_1), .rf_wr_select_o(sel_1), .rf_wr_en_o(en_1),
        .busy_o(busy_1), .overrun_o(ovr_1)
    );

    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic request(input logic m2r, input logic half, input logic sgn,
                           input logic [3:0] sel, input logic en, input logic [31:0] calc);
        wb_valid_i     = 1'b1;
        mem_to_reg_i   = m2r;
        ld_half_i      = half;
        ld_signed_i    = sgn;
        rf_wr_select_i = sel;
        rf_wr_en_i     = en;
        data_calc_i    = calc;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        total++; if (data_0 !== 32'h0) $display("FAIL reset_data: got %h want 00000000", data_0); else passed++;
        total++; if (sel_0 !== 4'h0) $display("FAIL reset_sel: got %h want 0", sel_0); else passed++;
        total++; if (en_0 !== 1'b0) $display("FAIL reset_en: got %b want 0", en_0); else passed++;
        total++; if (busy_0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_0); else passed++;
        total++; if (ovr_0 !== 1'b0) $display("FAIL reset_overrun: got %b want 0", ovr_0); else passed++;
    endtask

    task automatic test_alu_write;
        request(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 32'h1234_5678);
        step();
        wb_valid_i = 1'b0;
        total++; if (en_0 !== 1'b1) $display("FAIL alu_en: got %b want 1", en_0); else passed++;
        total++; if (data_0 !== 32'h1234_5678) $display("FAIL alu_data: got %h want 12345678", data_0); else passed++;
        total++; if (sel_0 !== 4'd3) $display("FAIL alu_sel: got %h want 3", sel_0); else passed++;
        total++; if (busy_0 !== 1'b0) $display("FAIL alu_busy: got %b want 0", busy_0); else passed++;
        step();
        total++; if (en_0 !== 1'b0) $display("FAIL alu_en_drop: got %b want 0", en_0); else passed++;
        total++; if (data_0 !== 32'h1234_5678) $display("FAIL alu_data_hold: got %h want 12345678", data_0); else passed++;
    endtask

    task automatic test_word_load;
        request(1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 32'hFFFF_FFFF);
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'hBEEF;
        total++; if (busy_0 !== 1'b1) $display("FAIL word_busy_t1: got %b want 1", busy_0); else passed++;
        total++; if (en_0 !== 1'b0) $display("FAIL word_en_t1: got %b want 0", en_0); else passed++;
        step();
        mem_rdata_i = 16'hDEAD;
        total++; if (busy_0 !== 1'b1) $display("FAIL word_busy_t2: got %b want 1", busy_0); else passed++;
        total++; if (busy_1 !== 1'b1) $display("FAIL word_busy_t2_hi: got %b want 1", busy_1); else passed++;
        step();
        mem_rdata_i = 16'h0000;
        total++; if (busy_0 !== 1'b0) $display("FAIL word_busy_t3: got %b want 0", busy_0); else passed++;
        total++; if (en_0 !== 1'b1) $display("FAIL word_en_t3: got %b want 1", en_0); else passed++;
        total++; if (data_0 !== 32'hDEAD_BEEF) $display("FAIL word_data_low_first: got %h want deadbeef", data_0); else passed++;
        total++; if (data_1 !== 32'hBEEF_DEAD) $display("FAIL word_data_high_first: got %h want beefdead", data_1); else passed++;
        total++; if (sel_0 !== 4'd5) $display("FAIL word_sel: got %h want 5", sel_0); else passed++;
        step();
        total++; if (en_0 !== 1'b0) $display("FAIL word_en_t4: got %b want 0", en_0); else passed++;
    endtask

    task automatic test_half_load(input logic sgn, input logic [31:0] exp);
        request(1'b1, 1'b1, sgn, 4'd7, 1'b1, 32'h0);
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'h8001;
        total++; if (busy_0 !== 1'b1) $display("FAIL half_busy_t1 s=%0b: got %b want 1", sgn, busy_0); else passed++;
        step();
        mem_rdata_i = 16'h0000;
        total++; if (busy_0 !== 1'b0) $display("FAIL half_busy_t2 s=%0b: got %b want 0", sgn, busy_0); else passed++;
        total++; if (en_0 !== 1'b1) $display("FAIL half_en s=%0b: got %b want 1", sgn, en_0); else passed++;
        total++; if (data_0 !== exp) $display("FAIL half_data s=%0b: got %h want %h", sgn, data_0, exp); else passed++;
        total++; if (data_1 !== exp) $display("FAIL half_data_hi s=%0b: got %h want %h", sgn, data_1, exp); else passed++;
        total++; if (sel_0 !== 4'd7) $display("FAIL half_sel s=%0b: got %h want 7", sgn, sel_0); else passed++;
        step();
    endtask

    task automatic test_overrun;
        request(1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 32'h0);
        step();
        request(1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 32'hAAAA_5555);
        mem_rdata_i = 16'h1111;
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'h2222;
        total++; if (ovr_0 !== 1'b1) $display("FAIL ovr_set: got %b want 1", ovr_0); else passed++;
        total++; if (busy_0 !== 1'b1) $display("FAIL ovr_busy: got %b want 1", busy_0); else passed++;
        total++; if (en_0 !== 1'b0) $display("FAIL ovr_ignored_en: got %b want 0", en_0); else passed++;
        step();
        total++; if (en_0 !== 1'b1) $display("FAIL ovr_load_en: got %b want 1", en_0); else passed++;
        total++; if (data_0 !== 32'h2222_1111) $display("FAIL ovr_load_data: got %h want 22221111", data_0); else passed++;
        total++; if (sel_0 !== 4'd2) $display("FAIL ovr_load_sel: got %h want 2", sel_0); else passed++;
        request(1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 32'hCAFE_F00D);
        step();
        wb_valid_i = 1'b0;
        total++; if (en_0 !== 1'b1) $display("FAIL ovr_next_en: got %b want 1", en_0); else passed++;
        total++; if (data_0 !== 32'hCAFE_F00D) $display("FAIL ovr_next_data: got %h want cafef00d", data_0); else passed++;
        total++; if (sel_0 !== 4'd4) $display("FAIL ovr_next_sel: got %h want 4", sel_0); else passed++;
        total++; if (ovr_0 !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", ovr_0); else passed++;
        step();
        total++; if (ovr_0 !== 1'b1) $display("FAIL ovr_sticky2: got %b want 1", ovr_0); else passed++;
    endtask

    task automatic test_mid_reset;
        request(1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 32'h0);
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'h1357;
        step();
        rst_i = 1'b1;
        mem_rdata_i = 16'h2468;
        step();
        rst_i = 1'b0;
        total++; if (busy_0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_0); else passed++;
        total++; if (en_0 !== 1'b0) $display("FAIL rst_en: got %b want 0", en_0); else passed++;
        total++; if (data_0 !== 32'h0) $display("FAIL rst_data: got %h want 00000000", data_0); else passed++;
        total++; if (ovr_0 !== 1'b0) $display("FAIL rst_overrun: got %b want 0", ovr_0); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (en_0 !== 1'b0 || busy_0 !== 1'b0) $display("FAIL rst_after_%0d: en=%b busy=%b want 0 0", i, en_0, busy_0); else passed++;
        end
    endtask

    task automatic test_no_enable;
        request(1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 32'h0);
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'h00FF;
        total++; if (busy_0 !== 1'b1 || en_0 !== 1'b0) $display("FAIL noen_t1: busy=%b en=%b want 1 0", busy_0, en_0); else passed++;
        step();
        mem_rdata_i = 16'h7700;
        total++; if (busy_0 !== 1'b1 || en_0 !== 1'b0) $display("FAIL noen_t2: busy=%b en=%b want 1 0", busy_0, en_0); else passed++;
        step();
        total++; if (busy_0 !== 1'b0 || en_0 !== 1'b0) $display("FAIL noen_t3: busy=%b en=%b want 0 0", busy_0, en_0); else passed++;
        total++; if (data_0 !== 32'h7700_00FF) $display("FAIL noen_data: got %h want 770000ff", data_0); else passed++;
        total++; if (sel_0 !== 4'd8) $display("FAIL noen_sel: got %h want 8", sel_0); else passed++;
        step();
        total++; if (en_0 !== 1'b0) $display("FAIL noen_t4: got %b want 0", en_0); else passed++;
    endtask

    task automatic test_back_to_back;
        request(1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 32'h0);
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'h0001;
        step();
        mem_rdata_i = 16'h0002;
        step();
        total++; if (en_0 !== 1'b1 || data_0 !== 32'h0002_0001) $display("FAIL b2b_word: en=%b data=%h want 1 00020001", en_0, data_0); else passed++;
        request(1'b1, 1'b1, 1'b1, 4'd10, 1'b1, 32'h0);
        step();
        wb_valid_i = 1'b0;
        mem_rdata_i = 16'hFFFE;
        total++; if (busy_0 !== 1'b1 || en_0 !== 1'b0) $display("FAIL b2b_accept: busy=%b en=%b want 1 0", busy_0, en_0); else passed++;
        step();
        total++; if (en_0 !== 1'b1 || data_0 !== 32'hFFFF_FFFE) $display("FAIL b2b_half: en=%b data=%h want 1 fffffffe", en_0, data_0); else passed++;
        total++; if (sel_0 !== 4'd10) $display("FAIL b2b_sel: got %h want a", sel_0); else passed++;
        total++; if (ovr_0 !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", ovr_0); else passed++;
    endtask

    initial begin
        step();
        test_reset();
        test_alu_write();
        test_word_load();
        test_half_load(1'b1, 32'hFFFF_8001);
        test_half_load(1'b0, 32'h0000_8001);
        test_overrun();
        test_mid_reset();
        test_no_enable();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/writeback_load_assemble.md
# writeback_load_assemble

Writeback stage directly downstream of the execute/memory stage. It takes the registered ALU result and register-file write controls, and passes ALU results to the register-file write port. For loads it collects the two sequential 16-bit data-memory reads (low half, then high half) and assembles them into one 32-bit register write. It also asserts a busy/stall indication while a load is in flight.

## Interface
- `HALF_FIRST_LOW`, default 1. 1: the first read beat is bits [15:0]. 0: the first read beat is bits [31:16].
- `clk_i` input 1: single clock; all state changes on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `wb_valid_i` input 1: an instruction result is presented this cycle (request).
- `data_calc_i` input 32: ALU result for non-load writes.
- `mem_to_reg_i` input 1: the request is a load; the write data comes from memory.
- `ld_half_i` input 1: the load is 16 bits, with a single read beat.
- `ld_signed_i` input 1: sign-extend a 16-bit load; otherwise zero-extend.
- `rf_wr_select_i` input 4: destination register index.
- `rf_wr_en_i` input 1: the request writes the register file.
- `mem_rdata_i` input 16: data-memory read beat.
- `rf_wr_data_o` output 32: register-file write data.
- `rf_wr_select_o` output 4: register-file write index.
- `rf_wr_en_o` output 1: register-file write strobe, one cycle per commit.
- `busy_o` output 1: combinational; high while a load is in flight. Upstream must not present requests while it is high.
- `overrun_o` output 1: sticky; set when a request arrives while busy. Cleared only by reset.

## Operation
- States: `ST_IDLE`, `ST_LOAD_A` (first beat), `ST_LOAD_B` (second beat).
- `ST_IDLE`, request with `mem_to_reg_i`=0:
  - register `rf_wr_data_o` <= `data_calc_i`, `rf_wr_select_o` <= `rf_wr_select_i`, `rf_wr_en_o` <= `rf_wr_en_i`.
  - Stay in `ST_IDLE`.
- `ST_IDLE`, request with `mem_to_reg_i`=1:
  - latch the select, write enable, `ld_half_i` and `ld_signed_i` into internal registers.
  - `rf_wr_en_o` <= 0. Go to `ST_LOAD_A`.
- `ST_IDLE`, no request: `rf_wr_en_o` <= 0; the data and select outputs hold their values.
- `ST_LOAD_A`:
  - Half load: commit the extended `mem_rdata_i` (bit 15 replicated if signed, else zeros). `rf_wr_en_o` <= latched enable. Go to `ST_IDLE`.
  - Word load: store the beat in `beat_a_q`. Go to `ST_LOAD_B`.
- `ST_LOAD_B`:
  - Commit `{mem_rdata_i, beat_a_q}` when `HALF_FIRST_LOW`=1, else `{beat_a_q, mem_rdata_i}`.
  - `rf_wr_en_o` <= latched enable. Go to `ST_IDLE`.
- `busy_o` = (state != `ST_IDLE`).
- A request while busy is ignored: no state change, no latch. `overrun_o` <= 1.
- A load with `rf_wr_en_i`=0 still runs through all its beats and commits no write (`rf_wr_en_o` stays 0). The data and select outputs still update.
- `ld_half_i` and `ld_signed_i` are ignored when `mem_to_reg_i`=0.
- Reset in mid-load abandons the load: no write is issued, and the state returns to `ST_IDLE`.

## Timing
- Reset values:
  - state `ST_IDLE`
  - `rf_wr_data_o` 0, `rf_wr_select_o` 0, `rf_wr_en_o` 0
  - `busy_o` 0, `overrun_o` 0, `beat_a_q` 0
- ALU write accepted in cycle T: outputs are valid in T+1, with `rf_wr_en_o` high for exactly one cycle.
- Word load accepted in T:
  - first beat sampled from `mem_rdata_i` during T+1
  - second beat sampled during T+2
  - write visible in T+3
  - `busy_o` high in T+1 and T+2.
- Half load accepted in T: beat sampled in T+1, write visible in T+2, `busy_o` high in T+1 only.
- Back-to-back: a new request is accepted in the same cycle the load commits (T+3 for a word load), so there is no bubble.
- `mem_rdata_i` is sampled only in `ST_LOAD_A` and `ST_LOAD_B`; it is don't-care otherwise.

## Test plan
- Reset, then ALU write with `data_calc_i`=0x1234_5678, select 4'd3, en=1:
  - cycle +1: `rf_wr_en_o`=1, data 0x1234_5678, select 3.
  - cycle +2: `rf_wr_en_o`=0.
- Word load to r5 with beats 0xBEEF then 0xDEAD, `HALF_FIRST_LOW`=1:
  - `busy_o` high for 2 cycles.
  - write 0xDEAD_BEEF to r5 at T+3.
  - Rerun with `HALF_FIRST_LOW`=0: write 0xBEEF_DEAD.
- Half loads of beat 0x8001:
  - signed: 0xFFFF_8001 at T+2.
  - unsigned: 0x0000_8001 at T+2.
  - `busy_o` high for one cycle.
- Request in T+1 of a word load: ignored, `overrun_o`=1 and stays set. The original load commits the correct data at T+3. A request in T+3 is accepted normally.
- Word load, then `rst_i` asserted in T+2: no write ever occurs, `busy_o`=0 and `rf_wr_data_o`=0 after reset.
- Load with `rf_wr_en_i`=0: passes through 2 busy cycles, and `rf_wr_en_o` stays 0 throughout.
